data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
- Single-clock controller that shares one data-memory instance between two requesters.
  - Port A: CPU load/store unit.
  - Port B: DMA/debug/IO.
- Round-robin arbitration; one memory operation issued per cycle.
- Built-in init engine sweeps every address and writes INIT_VALUE.
- Drives the memory's separate write and read ports. Both memory clock inputs are tied to Clock at the top level.

Parameters:
- DATA_WIDTH, 16, data word width (CPU_package value).
- ADDRESS_WIDTH, 8, address width (CPU_package value); init sweep covers 2**ADDRESS_WIDTH words.
- INIT_VALUE, 16'h0000, word written by the init sweep.

Ports:
- Clock  in  1  single clock for all logic.
- Reset_n  in  1  asynchronous, active-low reset.
- Init_start  in  1  pulse; request a full-memory init sweep.
- Init_busy  out  1  high while the sweep runs.
- Init_done  out  1  one-cycle pulse after the last init write.
- A_req_valid  in  1  port A request valid.
- A_req_ready  out  1  port A granted this cycle.
- A_req_write  in  1  1 = write, 0 = read.
- A_req_address  in  ADDRESS_WIDTH  port A address.
- A_req_wdata  in  DATA_WIDTH  port A write data.
- A_resp_valid  out  1  port A read data valid.
- A_resp_rdata  out  DATA_WIDTH  port A read data.
- B_req_valid, B_req_ready, B_req_write, B_req_address, B_req_wdata, B_resp_valid, B_resp_rdata: same as port A, for port B.
- Mem_write_enable  out  1  memory write strobe.
- Mem_write_address  out  ADDRESS_WIDTH  memory write address.
- Mem_write_data  out  DATA_WIDTH  memory write data.
- Mem_read_enable  out  1  memory read strobe.
- Mem_read_address  out  ADDRESS_WIDTH  memory read address.
- Mem_read_data  in  DATA_WIDTH  memory registered read output (1-cycle latency).

Behaviour:
- FSM states: IDLE, INIT. Reset (Reset_n low, async) forces:
  - state = IDLE, rr_ptr = A, init counter = 0.
  - Init_busy = 0, Init_done = 0, A_resp_valid = 0, B_resp_valid = 0.
- Combinational outputs (ready, Mem_* strobes) are 0 while Reset_n is low.
- IDLE grant rule:
  - Exactly one valid requester: it is granted.
  - Both valid: the requester named by rr_ptr is granted.
  - Grant = req_ready high in the same cycle, combinational from valid and state.
  - No req_valid: no grant, no memory strobe.
- rr_ptr update: flips to the other port only on a cycle where both were valid and one was granted; otherwise unchanged.
- Granted write: same cycle, Mem_write_enable = 1 with that port's address and data. Memory updates at the closing edge. No response.
- Granted read: same cycle, Mem_read_enable = 1 with that port's address. Next cycle, the port's resp_valid = 1 for exactly one cycle and resp_rdata = Mem_read_data.
- Read latency is 1 cycle, grant to response.
- At most one strobe (read or write) per cycle, so no same-address read/write collision exists.
- Back-to-back grants are allowed every cycle. Responses return in grant order.
- resp_rdata is don't-care when resp_valid = 0. The bench checks it only when valid.
- Init_start:
  - Sampled only in IDLE; ignored in INIT.
  - If Init_start and requests arrive in the same IDLE cycle, the requests are still granted that cycle and INIT begins the next cycle.
- INIT state:
  - Init_busy = 1; both req_ready = 0.
  - Each cycle: Mem_write_enable = 1, Mem_write_address = counter, Mem_write_data = INIT_VALUE; counter increments.
  - Sweep runs 0 to 2**ADDRESS_WIDTH-1, which is 256 cycles at default.
  - After the write to the last address: state returns to IDLE, counter returns to 0, Init_done pulses high for 1 cycle (coincident with the first IDLE cycle), Init_busy drops.
- A read response owed from the cycle before INIT is still delivered in the first INIT cycle.
- Reset mid-INIT aborts the sweep immediately. Memory contents are then partially initialised; software must re-issue Init_start.
- Request inputs must stay stable while valid and not ready (requester rule). The arbiter does not register requests.

Test Plan:
- Single-port: A writes 16'hBEEF to address 8'h10, then reads 8'h10 → ready same cycle both times; A_resp_valid one cycle after the read grant with 16'hBEEF; B_resp_valid stays 0.
- Contention: A and B both hold valid reads of 8'h01 and 8'h02 for 4 cycles after reset → grants A, B, A, B; responses alternate with matching data one cycle after each grant.
- Mixed back-to-back: A writes 8'h20 = 16'h1234 and B reads 8'h20 in the next cycle → B_resp_rdata = 16'h1234.
- Init: preload addresses 0, 127 and 255 with non-zero values, pulse Init_start → Init_busy high for 256 cycles; no ready during the sweep; Init_done pulses once; subsequent reads of 0, 127 and 255 return 16'h0000.
- Init overlap: pulse Init_start in the same cycle as an A read of 8'h05 → the read is granted and its response arrives in the first INIT cycle; a B request during INIT waits until after Init_done.
- Reset mid-init: assert Reset_n low at sweep cycle 100 → all outputs 0 asynchronously; after release, state is IDLE, Init_busy = 0, and the next contention is granted to A first.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Shares one dual-port data memory between a CPU port (A) and a DMA/debug port (B)
// with round-robin arbitration, plus a full-memory init sweep engine.
module data_memory_arbiter #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    ADDRESS_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Init_start,
  output logic                     Init_busy,
  output logic                     Init_done,
  input  logic                     A_req_valid,
  output logic                     A_req_ready,
  input  logic                     A_req_write,
  input  logic [ADDRESS_WIDTH-1:0] A_req_address,
  input  logic [DATA_WIDTH-1:0]    A_req_wdata,
  output logic                     A_resp_valid,
  output logic [DATA_WIDTH-1:0]    A_resp_rdata,
  input  logic                     B_req_valid,
  output logic                     B_req_ready,
  input  logic                     B_req_write,
  input  logic [ADDRESS_WIDTH-1:0] B_req_address,
  input  logic [DATA_WIDTH-1:0]    B_req_wdata,
  output logic                     B_resp_valid,
  output logic [DATA_WIDTH-1:0]    B_resp_rdata,
  output logic                     Mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] Mem_write_address,
  output logic [DATA_WIDTH-1:0]    Mem_write_data,
  output logic                     Mem_read_enable,
  output logic [ADDRESS_WIDTH-1:0] Mem_read_address,
  input  logic [DATA_WIDTH-1:0]    Mem_read_data
);

  // state  | meaning
  // S_IDLE | arbitrate A/B requests, one memory op per cycle
  // S_INIT | sweep every address writing INIT_VALUE, requests stalled
  typedef enum logic {S_IDLE, S_INIT} state_t;

  state_t                     state_q, state_d;
  logic                       rr_q, rr_d;          // 0 = A has priority, 1 = B
  logic [ADDRESS_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                       init_done_q, init_done_d;
  logic                       a_resp_q, a_resp_d;
  logic                       b_resp_q, b_resp_d;

  logic                       grant_a, grant_b;
  logic                       we, re;
  logic [ADDRESS_WIDTH-1:0]   wa, ra;
  logic [DATA_WIDTH-1:0]      wd;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = 1'b0;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    we          = 1'b0;
    wa          = '0;
    wd          = '0;
    re          = 1'b0;
    ra          = '0;
    case (state_q)
      S_IDLE: begin
        grant_a = A_req_valid && (!B_req_valid || !rr_q);
        grant_b = B_req_valid && (!A_req_valid ||  rr_q);
        if (A_req_valid && B_req_valid) rr_d = !rr_q;
        if (grant_a) begin
          if (A_req_write) begin
            we = 1'b1;
            wa = A_req_address;
            wd = A_req_wdata;
          end else begin
            re = 1'b1;
            ra = A_req_address;
          end
        end else if (grant_b) begin
          if (B_req_write) begin
            we = 1'b1;
            wa = B_req_address;
            wd = B_req_wdata;
          end else begin
            re = 1'b1;
            ra = B_req_address;
          end
        end
        // A same-cycle request is still served; the sweep starts next cycle.
        if (Init_start) state_d = S_INIT;
      end
      S_INIT: begin
        we = 1'b1;
        wa = init_cnt_q;
        wd = INIT_VALUE;
        if (init_cnt_q == {ADDRESS_WIDTH{1'b1}}) begin
          state_d     = S_IDLE;
          init_cnt_d  = '0;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_resp_d = grant_a && !A_req_write;
  assign b_resp_d = grant_b && !B_req_write;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      a_resp_q    <= 1'b0;
      b_resp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      a_resp_q    <= a_resp_d;
      b_resp_q    <= b_resp_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign A_req_ready       = Reset_n & grant_a;
  assign B_req_ready       = Reset_n & grant_b;
  assign Mem_write_enable  = Reset_n & we;
  assign Mem_write_address = Reset_n ? wa : '0;
  assign Mem_write_data    = Reset_n ? wd : '0;
  assign Mem_read_enable   = Reset_n & re;
  assign Mem_read_address  = Reset_n ? ra : '0;

  assign Init_busy    = (state_q == S_INIT);
  assign Init_done    = init_done_q;
  assign A_resp_valid = a_resp_q;
  assign B_resp_valid = b_resp_q;
  assign A_resp_rdata = Reset_n ? Mem_read_data : '0;
  assign B_resp_rdata = Reset_n ? Mem_read_data : '0;

endmodule
